// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO (1-cycle read latency) into a valid/ready stream
// through a 3-entry skid buffer, and counts delivered words.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    input  logic                  clr_cnt,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  busy
);

    logic [DATA_WIDTH-1:0] slot_mem [0:2];
    logic [1:0]            head;
    logic [1:0]            tail;
    logic [1:0]            occ;
    logic                  pend;
    logic [2:0]            in_flight;
    logic                  pop;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A slot is reserved for every outstanding read, so occ can never pass 3.
    // Gating with rst_ keeps the strobe low while the controller is held in reset.
    assign in_flight  = {1'b0, occ} + {2'b00, pend};
    assign fifo_rd_en = rst_ && enable && !fifo_empty && (in_flight < 3'd3);

    assign m_valid = (occ != 2'd0);
    assign m_data  = slot_mem[head];
    assign busy    = (occ != 2'd0) || pend;
    assign pop     = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            head     <= 2'd0;
            tail     <= 2'd0;
            occ      <= 2'd0;
            pend     <= 1'b0;
            word_cnt <= '0;
        end else begin
            pend <= fifo_rd_en;
            if (pend)
                tail <= next_ptr(tail);
            if (pop)
                head <= next_ptr(head);
            case ({pend, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
            // Clear wins over a coincident handshake; that word goes uncounted.
            if (clr_cnt)
                word_cnt <= '0;
            else if (pop)
                word_cnt <= word_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Data slots carry no reset; occ alone decides what is valid.
    always_ff @(posedge clk) begin
        if (pend)
            slot_mem[tail] <= fifo_dout;
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural 1-cycle-latency FIFO.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        fifo_rd_en;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready = 1'b0;
    logic        clr_cnt = 1'b0;
    logic [15:0] word_cnt;
    logic        busy;

    int checks = 0;
    int failures = 0;

    logic [7:0]  fmem [0:255];
    int unsigned rd_ptr = 0;
    int unsigned wr_ptr = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_(rst_), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
        .m_data(m_data), .m_ready(m_ready), .clr_cnt(clr_cnt),
        .word_cnt(word_cnt), .busy(busy)
    );

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= fmem[8'(rd_ptr)];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [7:0] d);
        fmem[8'(wr_ptr)] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        enable  = 1'b0;
        m_ready = 1'b0;
        clr_cnt = 1'b0;
        @(negedge clk);
        rst_ = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wr_ptr = rd_ptr;
        rst_ = 1'b1;
    endtask

    task automatic test_reset();
        int stale;
        do_reset();
        push(8'h11);
        push(8'h22);
        enable  = 1'b1;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b1) begin
            failures++; $display("FAIL reset_pre_valid: got %b expected 1", m_valid);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL reset_pre_busy: got %b expected 1", busy);
        end
        push(8'h33);
        rst_ = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b expected 0", m_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (word_cnt !== 16'h0000) begin
            failures++; $display("FAIL reset_cnt: got %h expected 0000", word_cnt);
        end
        checks++;
        if (fifo_rd_en !== 1'b0) begin
            failures++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en);
        end
        @(negedge clk);
        enable = 1'b0;
        wr_ptr = rd_ptr;
        rst_ = 1'b1;
        enable  = 1'b1;
        m_ready = 1'b1;
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (m_valid) stale++;
            @(negedge clk);
        end
        checks++;
        if (stale !== 0) begin
            failures++; $display("FAIL reset_stale: got %0d valid cycles expected 0", stale);
        end
    endtask

    task automatic test_single_word();
        int rd_cnt, rd_at, v_cnt, v_at;
        logic [7:0] v_data;
        do_reset();
        push(8'hA5);
        enable  = 1'b1;
        m_ready = 1'b1;
        rd_cnt = 0; rd_at = -1; v_cnt = 0; v_at = -1; v_data = 8'h00;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (fifo_rd_en) begin rd_cnt++; if (rd_at < 0) rd_at = k; end
            if (m_valid) begin v_cnt++; if (v_at < 0) begin v_at = k; v_data = m_data; end end
            @(negedge clk);
        end
        checks++;
        if (rd_cnt !== 1) begin
            failures++; $display("FAIL single_rd_pulses: got %0d expected 1", rd_cnt);
        end
        checks++;
        if (v_cnt !== 1) begin
            failures++; $display("FAIL single_valid_cycles: got %0d expected 1", v_cnt);
        end
        checks++;
        if (v_at - rd_at !== 2) begin
            failures++; $display("FAIL single_latency: got %0d expected 2", v_at - rd_at);
        end
        checks++;
        if (v_data !== 8'hA5) begin
            failures++; $display("FAIL single_data: got %h expected a5", v_data);
        end
        checks++;
        if (word_cnt !== 16'd1) begin
            failures++; $display("FAIL single_cnt: got %0d expected 1", word_cnt);
        end
    endtask

    task automatic test_streaming();
        int viol, first, last;
        logic [7:0] exp_d;
        do_reset();
        for (int i = 0; i < 16; i++) push(8'(i));
        enable  = 1'b1;
        m_ready = 1'b1;
        viol = 0; first = -1; last = -1; exp_d = 8'h00;
        for (int k = 0; k < 24; k++) begin
            #1;
            if (fifo_rd_en && fifo_empty) viol++;
            if (m_valid && m_ready) begin
                checks++;
                if (m_data !== exp_d) begin
                    failures++; $display("FAIL stream_data: got %h expected %h", m_data, exp_d);
                end
                if (first < 0) first = k;
                last  = k;
                exp_d = exp_d + 8'd1;
            end
            @(negedge clk);
        end
        checks++;
        if (viol !== 0) begin
            failures++; $display("FAIL stream_rd_when_empty: got %0d cycles expected 0", viol);
        end
        checks++;
        if (exp_d !== 8'd16) begin
            failures++; $display("FAIL stream_count: got %0d expected 16", exp_d);
        end
        checks++;
        if (first !== 2 || last - first !== 15) begin
            failures++; $display("FAIL stream_gaps: got first=%0d span=%0d expected first=2 span=15", first, last - first);
        end
        checks++;
        if (word_cnt !== 16'd16) begin
            failures++; $display("FAIL stream_cnt: got %0d expected 16", word_cnt);
        end
    endtask

    task automatic test_backpressure();
        int issued, delivered, occ_viol, unstable;
        logic [7:0] exp_d;
        do_reset();
        for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
        enable  = 1'b1;
        m_ready = 1'b0;
        issued = 0; delivered = 0; occ_viol = 0; unstable = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (fifo_rd_en) issued++;
            if (m_valid && m_data !== 8'h30) unstable++;
            if (issued - delivered > 3) occ_viol++;
            @(negedge clk);
        end
        checks++;
        if (issued !== 3) begin
            failures++; $display("FAIL bp_reads: got %0d expected 3", issued);
        end
        checks++;
        if (unstable !== 0 || m_valid !== 1'b1) begin
            failures++; $display("FAIL bp_hold: got %0d unstable cycles valid=%b expected 0 and 1", unstable, m_valid);
        end
        for (int j = 0; j < 60 && delivered < 8; j++) begin
            m_ready = (j % 2 == 0);
            #1;
            if (j == 0) begin
                checks++;
                if (fifo_rd_en !== 1'b0) begin
                    failures++; $display("FAIL bp_full_no_issue: got %b expected 0", fifo_rd_en);
                end
            end
            if (j == 1) begin
                checks++;
                if (fifo_rd_en !== 1'b1) begin
                    failures++; $display("FAIL bp_reissue: got %b expected 1", fifo_rd_en);
                end
            end
            if (fifo_rd_en) issued++;
            if (m_valid && m_ready) begin
                exp_d = 8'h30 + 8'(delivered);
                checks++;
                if (m_data !== exp_d) begin
                    failures++; $display("FAIL bp_data: got %h expected %h", m_data, exp_d);
                end
                delivered++;
            end
            if (issued - delivered > 3) occ_viol++;
            @(negedge clk);
        end
        checks++;
        if (delivered !== 8) begin
            failures++; $display("FAIL bp_delivered: got %0d expected 8", delivered);
        end
        checks++;
        if (occ_viol !== 0) begin
            failures++; $display("FAIL bp_occupancy: got %0d overflow cycles expected 0", occ_viol);
        end
        checks++;
        if (word_cnt !== 16'd8) begin
            failures++; $display("FAIL bp_cnt: got %0d expected 8", word_cnt);
        end
    endtask

    task automatic test_enable_drop();
        int rd_cnt, hs;
        logic [7:0] hs_data;
        logic busy2, busy3;
        do_reset();
        for (int i = 0; i < 4; i++) push(8'h50 + 8'(i));
        enable  = 1'b1;
        m_ready = 1'b1;
        rd_cnt = 0; hs = 0; hs_data = 8'h00; busy2 = 1'b0; busy3 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 1) enable = 1'b0;
            #1;
            if (fifo_rd_en) rd_cnt++;
            if (m_valid && m_ready) begin hs++; hs_data = m_data; end
            if (k == 2) busy2 = busy;
            if (k == 3) busy3 = busy;
            @(negedge clk);
        end
        checks++;
        if (rd_cnt !== 1) begin
            failures++; $display("FAIL endrop_reads: got %0d expected 1", rd_cnt);
        end
        checks++;
        if (hs !== 1 || hs_data !== 8'h50) begin
            failures++; $display("FAIL endrop_delivery: got %0d words last=%h expected 1 word 50", hs, hs_data);
        end
        checks++;
        if (busy2 !== 1'b1) begin
            failures++; $display("FAIL endrop_busy_hold: got %b expected 1", busy2);
        end
        checks++;
        if (busy3 !== 1'b0) begin
            failures++; $display("FAIL endrop_busy_fall: got %b expected 0", busy3);
        end
    endtask

    task automatic test_counter_edges();
        logic done;
        int hs;
        do_reset();
        wr_ptr  = wr_ptr + 65535;
        enable  = 1'b1;
        m_ready = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 70000; k++) begin
            #1;
            if (fifo_empty && !busy && !fifo_rd_en) begin done = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1) begin
            failures++; $display("FAIL cnt_bulk_timeout: got %b expected 1", done);
        end
        checks++;
        if (word_cnt !== 16'hFFFF) begin
            failures++; $display("FAIL cnt_preset: got %h expected ffff", word_cnt);
        end
        push(8'h77);
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (word_cnt !== 16'h0000) begin
            failures++; $display("FAIL cnt_wrap: got %h expected 0000", word_cnt);
        end
        push(8'h81);
        push(8'h82);
        hs = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            clr_cnt = (m_valid && m_ready && hs == 1);
            if (m_valid && m_ready) hs++;
            @(negedge clk);
            clr_cnt = 1'b0;
        end
        #1;
        checks++;
        if (hs !== 2 || word_cnt !== 16'h0000) begin
            failures++; $display("FAIL cnt_clr_priority: got %h after %0d words expected 0000 after 2", word_cnt, hs);
        end
        push(8'h83);
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (word_cnt !== 16'h0001) begin
            failures++; $display("FAIL cnt_after_clr: got %h expected 0001", word_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_streaming();
        test_backpressure();
        test_enable_drop();
        test_counter_edges();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
